// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional signed-overflow output is enabled with SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width for a given operand width (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, reused once per bit by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full_adder cell, registered carry loop.
// Build with SERIAL_ADD_OVF_EN to add the out_ovf signed-overflow output.
module bit_serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and the producer holds its data
  // stable while valid is high and ready is low.

  localparam int                     CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0]    CNT_LAST = CNT_BITS'(WIDTH - 1);

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic                carry;
  logic [WIDTH-1:0]    a_sh, b_sh, res;
  logic                fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic                c_msb_in;
`endif

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
`ifdef SERIAL_ADD_OVF_EN
      c_msb_in <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          res   <= {fa_s, res[WIDTH-1:1]};
          carry <= fa_c;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          if (cnt == CNT_LAST) c_msb_in <= carry;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, even before the first edge.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = rst_n && (state == DONE);
  assign out_sum   = out_valid ? res : '0;
  assign out_cout  = out_valid & carry;
`ifdef SERIAL_ADD_OVF_EN
  assign out_ovf   = out_valid & (c_msb_in ^ carry);
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8), scoreboard-based.
// Also exercises out_ovf when built with SERIAL_ADD_OVF_EN.
module tb_bit_serial_adder;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  state_t       dbg_state;

  // Scoreboard entry: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef SERIAL_ADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .dbg_state (dbg_state)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign out_ovf = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one op, waits for the result, holds out_ready low for 'hold' cycles
  // (optionally pulsing in_valid), then compares against the scoreboard.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input bit pulse);
    logic [W+1:0] e;
    logic [W-1:0] s0;
    logic         c0;
    int           lat;
    check("in_ready_idle", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    exp_q.push_back(model(a, b, cin));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W);
    s0 = out_sum;
    c0 = out_cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse ? ((i % 2) == 0) : 1'b0;
      @(posedge clk); #1;
      if (pulse) begin
        check("hold_sum", out_sum, s0);
        check("hold_cout", out_cout, c0);
        check("hold_in_ready", in_ready, 0);
        check("hold_state", dbg_state, DONE);
      end
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check("out_valid", out_valid, 1);
    check("sum", out_sum, e[W-1:0]);
    check("cout", out_cout, e[W]);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", out_ovf, e[W+1]);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;
    #1;
    check("idle_state", dbg_state, IDLE);

    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1, 1'b0);
    // Backpressure: 5 cycles in DONE with in_valid pulsing.
    run_op(8'h3C, 8'hC4, 1'b1, 5, 1'b1);
    check("no_new_accept", dbg_state, IDLE);

    // Reset while processing bit 3.
    in_a = 8'hFF; in_b = 8'h01; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_state", dbg_state, RUN);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("abandoned_no_valid", out_valid, 0);
    end
    run_op(8'h12, 8'h34, 1'b0, 0, 1'b0);

    // Random ops with random consumer stall.
    for (int n = 0; n < 1000; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
